// File: rtl/link_stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// link_stack_ctrl_if
// Groups the handshake and status signals between the control unit and the
// CALL/RET link-address stack controller.
//
// Signals
//   call_req    control -> stack   CALL request, held until call_ack
//   ret_req     control -> stack   RET request, held until ret_ack
//   pc_next     control -> stack   PC+1, captured when a CALL is accepted
//   clr_err     control -> stack   clears the sticky ovf/udf flags
//   call_ack    stack -> control   one-cycle pulse, CALL address stored
//   ret_ack     stack -> control   one-cycle pulse, RET address valid
//   ret_addr    stack -> PC mux    return address, valid with pc_load_en
//   pc_load_en  stack -> PC mux    one-cycle strobe, PC <= ret_addr
//   busy        stack -> control   controller is not idle
//   depth_cnt   stack -> control   number of valid entries, 0..DEPTH
//   ovf / udf   stack -> control   sticky overflow / underflow flags
//
// Modports
//   master : control unit side (drives requests)
//   slave  : stack controller side (drives acks and status)
// ---------------------------------------------------------------------------
interface link_stack_ctrl_if #(
    parameter int AW = 8,
    parameter int PW = 2
);
    logic          call_req;
    logic          ret_req;
    logic [AW-1:0] pc_next;
    logic          clr_err;
    logic          call_ack;
    logic          ret_ack;
    logic [AW-1:0] ret_addr;
    logic          pc_load_en;
    logic          busy;
    logic [PW:0]   depth_cnt;
    logic          ovf;
    logic          udf;

    modport master (
        output call_req, ret_req, pc_next, clr_err,
        input  call_ack, ret_ack, ret_addr, pc_load_en, busy, depth_cnt, ovf, udf
    );

    modport slave (
        input  call_req, ret_req, pc_next, clr_err,
        output call_ack, ret_ack, ret_addr, pc_load_en, busy, depth_cnt, ovf, udf
    );
endinterface

// File: rtl/link_stack_ctrl.sv
// ---------------------------------------------------------------------------
// link_stack_ctrl
// CALL/RET link-address sequencer for the 8-bit RISC core. Keeps a DEPTH-entry
// circular return-address stack whose top acts as the link register. A CALL
// pushes the captured PC+1; a RET pops the top entry and hands it to the PC
// mux together with a one-cycle load strobe.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   lsBus   slave modport of link_stack_ctrl_if (requests, acks, status)
//
// Timing (T = IDLE cycle in which the request is sampled)
//   CALL : call_ack high in T+1, entry and depth_cnt updated from T+2
//   RET  : ret_addr / pc_load_en / ret_ack valid in T+2
// ---------------------------------------------------------------------------
module link_stack_ctrl #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    link_stack_ctrl_if.slave lsBus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        RDY  = 2'd3
    } state_t;

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [PW-1:0] sp_q, sp_d;
    logic [PW:0]   depth_q, depth_d;
    logic [AW-1:0] pcHold_q, pcHold_d;
    logic [AW-1:0] retAddr_q, retAddr_d;
    logic          callAck_q, callAck_d;
    logic          retAck_q, retAck_d;
    logic          pcLoad_q, pcLoad_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [AW-1:0] stackMem [DEPTH];
    logic [PW-1:0] spDec;

    // The pointer always addresses the next free slot, so the top of stack
    // lives one below it; the subtraction wraps naturally modulo DEPTH.
    assign spDec = sp_q - 1'b1;

    // Stack storage has no reset: only entries written since reset are ever
    // read back, because depth_cnt never counts a slot that was not pushed.
    // The write uses the PC value held at accept time, not the live input.
    always_ff @(posedge clk) begin
        if (state_q == PUSH) begin
            stackMem[sp_q] <= pcHold_q;
        end
    end

    // All control state and every output is registered here so that nothing
    // on the request side reaches an ack or strobe combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            depth_q   <= '0;
            pcHold_q  <= '0;
            retAddr_q <= '0;
            callAck_q <= 1'b0;
            retAck_q  <= 1'b0;
            pcLoad_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            depth_q   <= depth_d;
            pcHold_q  <= pcHold_d;
            retAddr_q <= retAddr_d;
            callAck_q <= callAck_d;
            retAck_q  <= retAck_d;
            pcLoad_q  <= pcLoad_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Next-state logic. Ack and strobe registers are loaded on the edge that
    // enters the state they belong to, so call_ack is high during PUSH and
    // pc_load_en/ret_ack are high during RDY. CALL wins over RET in IDLE; a
    // RET left pending simply gets picked up on the next IDLE cycle. clr_err
    // is applied first so that a set event in the same cycle overrides it.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        pcHold_d  = pcHold_q;
        retAddr_d = retAddr_q;
        callAck_d = 1'b0;
        retAck_d  = 1'b0;
        pcLoad_d  = 1'b0;
        ovf_d     = lsBus.clr_err ? 1'b0 : ovf_q;
        udf_d     = lsBus.clr_err ? 1'b0 : udf_q;

        case (state_q)
            IDLE: begin
                if (lsBus.call_req) begin
                    state_d   = PUSH;
                    pcHold_d  = lsBus.pc_next;
                    callAck_d = 1'b1;
                end else if (lsBus.ret_req) begin
                    state_d = POP;
                end
            end

            PUSH: begin
                // A full stack still accepts the push; the wrap overwrites the
                // oldest entry and the count saturates at DEPTH.
                sp_d = sp_q + 1'b1;
                if (depth_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    depth_d = depth_q + 1'b1;
                end
                state_d = IDLE;
            end

            POP: begin
                // Popping an empty stack vectors the core to address zero and
                // leaves the pointer where it is.
                if (depth_q == '0) begin
                    retAddr_d = '0;
                    udf_d     = 1'b1;
                end else begin
                    sp_d      = spDec;
                    retAddr_d = stackMem[spDec];
                    depth_d   = depth_q - 1'b1;
                end
                pcLoad_d = 1'b1;
                retAck_d = 1'b1;
                state_d  = RDY;
            end

            RDY: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lsBus.call_ack   = callAck_q;
    assign lsBus.ret_ack    = retAck_q;
    assign lsBus.ret_addr   = retAddr_q;
    assign lsBus.pc_load_en = pcLoad_q;
    assign lsBus.busy       = (state_q != IDLE);
    assign lsBus.depth_cnt  = depth_q;
    assign lsBus.ovf        = ovf_q;
    assign lsBus.udf        = udf_q;

endmodule

// File: tb/tb_link_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_link_stack_ctrl
// Self-checking bench for link_stack_ctrl (AW=8, DEPTH=4). A directed table
// walks the basic CALL/RET, nesting, overflow and underflow cases, a hand
// sequence covers simultaneous requests with a reset in the middle of a POP,
// and a random phase compares against a queue-based model of the stack.
// ---------------------------------------------------------------------------
module tb_link_stack_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic clk;
    logic rst_n;

    link_stack_ctrl_if #(.AW(AW), .PW(PW)) lsIf ();

    link_stack_ctrl #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsBus (lsIf.slave)
    );

    typedef enum int {OP_CALL, OP_RET, OP_CLR} op_t;

    typedef struct {
        op_t        op;
        logic [7:0] addr;
        logic [7:0] expAddr;
        logic [2:0] expDepth;
        logic       expOvf;
        logic       expUdf;
    } vec_t;

    int nChecks = 0;
    int nFail   = 0;

    // Free-running clock; inputs change and outputs are sampled on the
    // falling edge, well away from the rising edge the design uses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Holds reset for two cycles, checks the reset state, then releases on a
    // falling edge.
    task automatic applyReset();
        lsIf.call_req = 1'b0;
        lsIf.ret_req  = 1'b0;
        lsIf.clr_err  = 1'b0;
        lsIf.pc_next  = 8'hA5;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset depth_cnt", 32'(lsIf.depth_cnt), 0);
        checkOutput("reset busy", 32'(lsIf.busy), 0);
        checkOutput("reset ovf", 32'(lsIf.ovf), 0);
        checkOutput("reset udf", 32'(lsIf.udf), 0);
        checkOutput("reset pc_load_en", 32'(lsIf.pc_load_en), 0);
        checkOutput("reset ret_addr", 32'(lsIf.ret_addr), 0);
        checkOutput("reset call_ack", 32'(lsIf.call_ack), 0);
        checkOutput("reset ret_ack", 32'(lsIf.ret_ack), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One CALL from IDLE. pc_next is scrambled once the CALL is accepted to
    // prove the stored value is the one captured at accept time. clr_err, if
    // requested, is held across the whole transaction.
    task automatic doCall(input logic [7:0] addr, input logic clr,
                          output logic [2:0] dep, output logic ovfO, output logic udfO);
        int lat;
        lsIf.call_req = 1'b1;
        lsIf.pc_next  = addr;
        lsIf.clr_err  = clr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!lsIf.call_ack && lat < 8);
        checkOutput("call_ack latency", 32'(lat), 1);
        checkOutput("busy during push", 32'(lsIf.busy), 1);
        lsIf.call_req = 1'b0;
        lsIf.pc_next  = ~addr;
        @(negedge clk);
        checkOutput("call_ack single pulse", 32'(lsIf.call_ack), 0);
        checkOutput("busy after call", 32'(lsIf.busy), 0);
        dep          = lsIf.depth_cnt;
        ovfO         = lsIf.ovf;
        udfO         = lsIf.udf;
        lsIf.clr_err = 1'b0;
    endtask

    // One RET from IDLE; results are sampled in the cycle carrying the strobe.
    task automatic doRet(input logic clr, output logic [7:0] addrO,
                         output logic [2:0] dep, output logic ovfO, output logic udfO);
        int lat;
        lsIf.ret_req = 1'b1;
        lsIf.clr_err = clr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!lsIf.pc_load_en && lat < 8);
        checkOutput("pc_load_en latency", 32'(lat), 2);
        checkOutput("ret_ack with strobe", 32'(lsIf.ret_ack), 1);
        addrO        = lsIf.ret_addr;
        dep          = lsIf.depth_cnt;
        ovfO         = lsIf.ovf;
        udfO         = lsIf.udf;
        lsIf.ret_req = 1'b0;
        lsIf.clr_err = 1'b0;
        @(negedge clk);
        checkOutput("pc_load_en single pulse", 32'(lsIf.pc_load_en), 0);
        checkOutput("ret_ack single pulse", 32'(lsIf.ret_ack), 0);
        checkOutput("ret_addr held", 32'(lsIf.ret_addr), 32'(addrO));
        checkOutput("busy after ret", 32'(lsIf.busy), 0);
    endtask

    task automatic doClear(output logic [2:0] dep, output logic ovfO, output logic udfO);
        lsIf.clr_err = 1'b1;
        @(negedge clk);
        lsIf.clr_err = 1'b0;
        dep  = lsIf.depth_cnt;
        ovfO = lsIf.ovf;
        udfO = lsIf.udf;
    endtask

    // Executes one table record and compares against its expected values.
    task automatic applyStimulus(input int idx, input vec_t v);
        logic [7:0] a;
        logic [2:0] dep;
        logic       o;
        logic       u;
        a = 8'h00;
        case (v.op)
            OP_CALL: doCall(v.addr, 1'b0, dep, o, u);
            OP_RET: begin
                doRet(1'b0, a, dep, o, u);
                checkOutput($sformatf("vec%0d ret_addr", idx), 32'(a), 32'(v.expAddr));
            end
            default: doClear(dep, o, u);
        endcase
        checkOutput($sformatf("vec%0d depth_cnt", idx), 32'(dep), 32'(v.expDepth));
        checkOutput($sformatf("vec%0d ovf", idx), 32'(o), 32'(v.expOvf));
        checkOutput($sformatf("vec%0d udf", idx), 32'(u), 32'(v.expUdf));
    endtask

    initial begin
        vec_t       vecs[20];
        logic [7:0] modelQ[$];
        logic       ovfM;
        logic       udfM;
        logic [7:0] a;
        logic [7:0] expA;
        logic [2:0] dep;
        logic       o;
        logic       u;
        logic       sawLoad;

        // Directed sequence from reset, DEPTH=4.
        vecs[0]  = '{OP_CALL, 8'h12, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{OP_RET,  8'h00, 8'h12, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{OP_CALL, 8'h10, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{OP_CALL, 8'h20, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{OP_CALL, 8'h30, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[5]  = '{OP_RET,  8'h00, 8'h30, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{OP_RET,  8'h00, 8'h20, 3'd1, 1'b0, 1'b0};
        vecs[7]  = '{OP_RET,  8'h00, 8'h10, 3'd0, 1'b0, 1'b0};
        vecs[8]  = '{OP_CALL, 8'h01, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{OP_CALL, 8'h02, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[10] = '{OP_CALL, 8'h03, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{OP_CALL, 8'h04, 8'h00, 3'd4, 1'b0, 1'b0};
        vecs[12] = '{OP_CALL, 8'h05, 8'h00, 3'd4, 1'b1, 1'b0};
        vecs[13] = '{OP_RET,  8'h00, 8'h05, 3'd3, 1'b1, 1'b0};
        vecs[14] = '{OP_RET,  8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[15] = '{OP_RET,  8'h00, 8'h03, 3'd1, 1'b1, 1'b0};
        vecs[16] = '{OP_RET,  8'h00, 8'h02, 3'd0, 1'b1, 1'b0};
        vecs[17] = '{OP_CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[18] = '{OP_RET,  8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[19] = '{OP_CLR,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        rst_n         = 1'b1;
        lsIf.call_req = 1'b0;
        lsIf.ret_req  = 1'b0;
        lsIf.clr_err  = 1'b0;
        lsIf.pc_next  = 8'h00;

        applyReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Simultaneous CALL and RET, then reset while the POP is in flight.
        applyReset();
        lsIf.call_req = 1'b1;
        lsIf.ret_req  = 1'b1;
        lsIf.pc_next  = 8'h44;
        @(negedge clk);
        checkOutput("t6 call_ack first", 32'(lsIf.call_ack), 1);
        checkOutput("t6 no strobe in push", 32'(lsIf.pc_load_en), 0);
        lsIf.call_req = 1'b0;
        lsIf.pc_next  = 8'h00;
        @(negedge clk);
        checkOutput("t6 depth after call", 32'(lsIf.depth_cnt), 1);
        @(negedge clk);
        checkOutput("t6 busy in pop", 32'(lsIf.busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 busy after reset", 32'(lsIf.busy), 0);
        checkOutput("t6 depth after reset", 32'(lsIf.depth_cnt), 0);
        checkOutput("t6 strobe after reset", 32'(lsIf.pc_load_en), 0);
        lsIf.ret_req = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        sawLoad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (lsIf.pc_load_en) sawLoad = 1'b1;
        end
        checkOutput("t6 no lost strobe", 32'(sawLoad), 0);

        // Random phase against a queue model: the newest entry is at the back,
        // a full stack drops its oldest entry, an empty pop yields zero.
        applyReset();
        modelQ.delete();
        ovfM = 1'b0;
        udfM = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int   sel;
            logic clr;
            logic [7:0] addr;
            sel  = int'($urandom_range(0, 9));
            clr  = ($urandom_range(0, 5) == 0);
            addr = 8'($urandom_range(0, 255));
            if (sel < 5) begin
                doCall(addr, clr, dep, o, u);
                if (clr) begin
                    ovfM = 1'b0;
                    udfM = 1'b0;
                end
                if (modelQ.size() == DEPTH) begin
                    void'(modelQ.pop_front());
                    ovfM = 1'b1;
                end
                modelQ.push_back(addr);
            end else if (sel < 9) begin
                doRet(clr, a, dep, o, u);
                if (clr) begin
                    ovfM = 1'b0;
                    udfM = 1'b0;
                end
                if (modelQ.size() == 0) begin
                    expA = 8'h00;
                    udfM = 1'b1;
                end else begin
                    expA = modelQ.pop_back();
                end
                checkOutput($sformatf("rand%0d ret_addr", n), 32'(a), 32'(expA));
            end else begin
                doClear(dep, o, u);
                ovfM = 1'b0;
                udfM = 1'b0;
            end
            checkOutput($sformatf("rand%0d depth_cnt", n), 32'(dep), 32'(modelQ.size()));
            checkOutput($sformatf("rand%0d ovf", n), 32'(o), 32'(ovfM));
            checkOutput($sformatf("rand%0d udf", n), 32'(u), 32'(udfM));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
